alu_vec_sequencer: RTL and testbench

Sequencing stage wrapped around the vector ALU array. Upstream, it collects ALUS_NUM operand pairs from a serial valid/ready stream into lane registers, then drives the array's A/B/opcode/enable for exactly one cycle. Downstream, it captures the array's per-lane results and compare flags and drains them lane by lane on a serial valid/ready output stream. It turns the combinational array into a flow-controlled, registered pipeline stage.

---
 rtl/alu_vec_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_vec_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_sequencer.sv
// Flow-controlled wrapper around the combinational vector ALU array:
// serial operand collection, one-cycle execute, registered serial result drain.

module alu_vec_sequencer_lane #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_en_i,
  input  logic           cap_en_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [2*W-1:0] res_i,
  input  logic [2:0]     flg_i,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o,
  output logic [2*W-1:0] res_o,
  output logic [2:0]     flg_o
);
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] res_q;
  logic [2:0]     flg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (ld_en_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (cap_en_i) begin
        res_q <= res_i;
        flg_q <= flg_i;
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign res_o = res_q;
  assign flg_o = flg_q;
endmodule

module alu_vec_sequencer #(
  parameter  int ALUS_NUM    = 4,
  parameter  int INPUT_WIDTH = 8,
  localparam int LW          = (ALUS_NUM > 1) ? $clog2(ALUS_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   in_a,
  input  logic [INPUT_WIDTH-1:0]   in_b,
  input  logic [3:0]               in_opcode,
  output logic [INPUT_WIDTH-1:0]   alu_a [ALUS_NUM],
  output logic [INPUT_WIDTH-1:0]   alu_b [ALUS_NUM],
  output logic [3:0]               alu_opcode,
  output logic                     alu_enable,
  input  logic [2*INPUT_WIDTH-1:0] alu_result [ALUS_NUM],
  input  logic [ALUS_NUM-1:0]      alu_greater,
  input  logic [ALUS_NUM-1:0]      alu_equal,
  input  logic [ALUS_NUM-1:0]      alu_less,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*INPUT_WIDTH-1:0] out_result,
  output logic [2:0]               out_flags,
  output logic [LW-1:0]            out_lane,
  output logic                     out_last
);
  typedef enum logic [1:0] {LOAD, EXEC, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            idx_q, idx_d;
  logic [3:0]               op_q, op_d;
  logic                     accept, last_lane;
  logic [2*INPUT_WIDTH-1:0] cap_res [ALUS_NUM];
  logic [2:0]               cap_flg [ALUS_NUM];

  assign last_lane  = (idx_q == LW'(ALUS_NUM - 1));
  assign in_ready   = (state_q == LOAD) && !rst;
  assign accept     = in_valid && in_ready;
  assign alu_enable = (state_q == EXEC) && !rst;
  assign out_valid  = (state_q == DRAIN) && !rst;
  assign alu_opcode = op_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    case (state_q)
      LOAD: if (accept) begin
        if (idx_q == '0) op_d = in_opcode;
        if (last_lane) begin
          idx_d   = '0;
          state_d = EXEC;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      EXEC: state_d = DRAIN;
      DRAIN: if (out_ready) begin
        if (last_lane) begin
          idx_d   = '0;
          state_d = LOAD;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  // Capture happens on the single EXEC cycle; outside it the array outputs are ignored.
  for (genvar i = 0; i < ALUS_NUM; i++) begin : g_lane
    alu_vec_sequencer_lane #(.W(INPUT_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld_en_i  (accept && (idx_q == LW'(i))),
      .cap_en_i (state_q == EXEC),
      .a_i      (in_a),
      .b_i      (in_b),
      .res_i    (alu_result[i]),
      .flg_i    ({alu_greater[i], alu_equal[i], alu_less[i]}),
      .a_o      (alu_a[i]),
      .b_o      (alu_b[i]),
      .res_o    (cap_res[i]),
      .flg_o    (cap_flg[i])
    );
  end

  always_comb begin
    out_result = '0;
    out_flags  = '0;
    out_lane   = '0;
    out_last   = 1'b0;
    if (out_valid) begin
      out_result = cap_res[idx_q];
      out_flags  = cap_flg[idx_q];
      out_lane   = idx_q;
      out_last   = last_lane;
    end
  end
endmodule

// File: tb/tb_alu_vec_sequencer.sv
// Bench for alu_vec_sequencer: stub ALU, queue-based reference model, directed scenarios.

module tb_alu_vec_sequencer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_opcode;
  logic [7:0]  alu_a [N];
  logic [7:0]  alu_b [N];
  logic [3:0]  alu_opcode;
  logic        alu_enable;
  logic [15:0] alu_result [N];
  logic [N-1:0] alu_greater, alu_equal, alu_less;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  logic [1:0]  out_lane;
  logic        out_last;

  always #5 clk = ~clk;

  alu_vec_sequencer #(.ALUS_NUM(N), .INPUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_greater(alu_greater), .alu_equal(alu_equal), .alu_less(alu_less),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_lane(out_lane), .out_last(out_last)
  );

  // Stub array; junk when disabled so a stray capture is visible.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      alu_result[i]  = alu_enable ? {alu_a[i], alu_b[i]} : 16'hDEAD;
      alu_greater[i] = alu_enable ? (alu_a[i] >  alu_b[i]) : 1'b1;
      alu_equal[i]   = alu_enable ? (alu_a[i] == alu_b[i]) : 1'b1;
      alu_less[i]    = alu_enable ? (alu_a[i] <  alu_b[i]) : 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] r;
    logic [2:0]  f;
    int          lane;
    bit          last;
  } beat_t;

  // Reference model: vector contents plus a queue of beats still owed downstream.
  logic [7:0] ma [N];
  logic [7:0] mb [N];
  logic [3:0] mop;
  int         mlanes;
  bit         mexec;
  beat_t      mq[$];
  beat_t      got[$];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
    mop = '0; mlanes = 0; mexec = 0; mq.delete();
  endtask

  initial model_clear();

  always @(negedge clk) begin
    chk("in_ready", in_ready, !rst && !mexec && mq.size() == 0);
    if (!rst) begin
      chk("alu_enable", alu_enable, mexec);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("alu_opcode", alu_opcode, mop);
      for (int i = 0; i < N; i++) begin
        chk("alu_a", alu_a[i], ma[i]);
        chk("alu_b", alu_b[i], mb[i]);
      end
      if (mq.size() != 0) begin
        chk("out_result", out_result, mq[0].r);
        chk("out_flags", out_flags, mq[0].f);
        chk("out_lane", out_lane, mq[0].lane);
        chk("out_last", out_last, mq[0].last);
      end
      if (out_valid && out_ready)
        got.push_back('{r: out_result, f: out_flags, lane: int'(out_lane), last: out_last});
    end
    if (rst) model_clear();
    else if (mexec) begin
      for (int i = 0; i < N; i++)
        mq.push_back('{r: {ma[i], mb[i]}, f: {ma[i] > mb[i], ma[i] == mb[i], ma[i] < mb[i]},
                       lane: i, last: (i == N - 1)});
      mexec = 0;
    end else if (mq.size() != 0) begin
      if (out_ready) void'(mq.pop_front());
    end else if (in_valid) begin
      ma[mlanes] = in_a;
      mb[mlanes] = in_b;
      if (mlanes == 0) mop = in_opcode;
      mlanes++;
      if (mlanes == N) begin mlanes = 0; mexec = 1; end
    end
  end

  logic [15:0] exp_r [12];
  logic [2:0]  exp_f [12];

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int c;
    in_a = a; in_b = b; in_opcode = op; in_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 300) begin c++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 400 && got.size() < n; c++) @(posedge clk);
    #1;
    chk("beat_count", got.size(), n);
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    @(negedge clk);
    while (!out_valid && c < 100) begin c++; @(negedge clk); end
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic chk_got(input int n);
    for (int k = 0; k < n && k < got.size(); k++) begin
      chk("beat_result", got[k].r, exp_r[k]);
      chk("beat_flags", got[k].f, exp_f[k]);
      chk("beat_lane", got[k].lane, k % N);
      chk("beat_last", got[k].last, (k % N) == N - 1);
    end
  endtask

  task automatic set_exp4(input logic [15:0] r0, input logic [2:0] f0, input logic [15:0] r1,
                          input logic [2:0] f1, input logic [15:0] r2, input logic [2:0] f2,
                          input logic [15:0] r3, input logic [2:0] f3);
    exp_r[0] = r0; exp_f[0] = f0; exp_r[1] = r1; exp_f[1] = f1;
    exp_r[2] = r2; exp_f[2] = f2; exp_r[3] = r3; exp_f[3] = f3;
  endtask

  task automatic send_vec1();
    send(8'h05, 8'h03, 4'h2);
    send(8'h07, 8'h07, 4'h2);
    send(8'h01, 8'h09, 4'h2);
    send(8'hFF, 8'h00, 4'h2);
  endtask

  logic [7:0] a6 [12];
  logic [7:0] b6 [12];
  bit running;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_alu_a0", alu_a[0], 0);
    @(posedge clk); #1;

    // 1: basic vector, latency
    out_ready = 1'b1; got.delete();
    send_vec1();
    @(negedge clk);
    chk("s1_enable", alu_enable, 1);
    chk("s1_opcode", alu_opcode, 4'h2);
    chk("s1_no_valid_yet", out_valid, 0);
    @(negedge clk);
    chk("s1_latency", out_valid, 1);
    chk("s1_enable_off", alu_enable, 0);
    wait_beats(4);
    set_exp4(16'h0503, 3'b100, 16'h0707, 3'b010, 16'h0109, 3'b001, 16'hFF00, 3'b100);
    chk_got(4);

    // 2: backpressure on lane 1
    out_ready = 1'b0; got.delete();
    send_vec1();
    wait_valid();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("s2_hold_valid", out_valid, 1);
      chk("s2_hold_lane", out_lane, 1);
      chk("s2_hold_result", out_result, 16'h0707);
      chk("s2_hold_flags", out_flags, 3'b010);
      chk("s2_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_beats(4);
    chk_got(4);

    // 3: gapped in_valid, opcode only from lane 0
    got.delete();
    send(8'h10, 8'h20, 4'hA); @(posedge clk); #1;
    send(8'h30, 8'h30, 4'h5); @(posedge clk); #1;
    send(8'h80, 8'h7F, 4'h3); @(posedge clk); #1;
    send(8'h00, 8'h01, 4'h7);
    @(negedge clk);
    chk("s3_enable", alu_enable, 1);
    chk("s3_opcode", alu_opcode, 4'hA);
    wait_beats(4);
    set_exp4(16'h1020, 3'b001, 16'h3030, 3'b010, 16'h807F, 3'b100, 16'h0001, 3'b001);
    chk_got(4);

    // 4: reset after two lanes loaded
    got.delete();
    send(8'h01, 8'h02, 4'h9);
    send(8'h03, 8'h04, 4'h9);
    rst = 1'b1;
    @(negedge clk);
    chk("s4_rst_in_ready", in_ready, 0);
    chk("s4_rst_enable", alu_enable, 0);
    chk("s4_rst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("s4_cleared_a0", alu_a[0], 0);
    chk("s4_cleared_op", alu_opcode, 0);
    @(posedge clk); #1;
    send(8'h09, 8'h09, 4'h4);
    send(8'h20, 8'h10, 4'h4);
    send(8'h00, 8'hFF, 4'h4);
    send(8'h44, 8'h45, 4'h4);
    wait_beats(4);
    set_exp4(16'h0909, 3'b010, 16'h2010, 3'b100, 16'h00FF, 3'b001, 16'h4445, 3'b001);
    chk_got(4);

    // 5: reset during drain of lane 2
    out_ready = 1'b0; got.delete();
    send(8'h01, 8'h01, 4'h1);
    send(8'h02, 8'h02, 4'h1);
    send(8'h03, 8'h03, 4'h1);
    send(8'h04, 8'h04, 4'h1);
    wait_valid();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("s5_lane2", out_lane, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("s5_out_valid_off", out_valid, 0);
    chk("s5_in_ready_on", in_ready, 1);
    chk("s5_beats_seen", got.size(), 2);
    @(posedge clk); #1;

    // 6: three back-to-back vectors, random downstream stalls
    a6 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h55, 8'h00, 8'hFE, 8'h01, 8'h80, 8'h7F, 8'hC3};
    b6 = '{8'h11, 8'h20, 8'h2F, 8'h41, 8'h55, 8'h54, 8'h01, 8'hFE, 8'h02, 8'h7F, 8'h7F, 8'h3C};
    for (int k = 0; k < 12; k++) begin
      exp_r[k] = {a6[k], b6[k]};
      exp_f[k] = {a6[k] > b6[k], a6[k] == b6[k], a6[k] < b6[k]};
    end
    got.delete(); running = 1'b1;
    fork
      begin
        for (int k = 0; k < 12; k++) send(a6[k], b6[k], 4'(k / N + 1));
        wait_beats(12);
        running = 1'b0;
      end
      begin
        while (running) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    chk_got(12);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
